// File: rtl/fp16_pkg.sv
// Shared constants and state encoding for the FP16 accumulation sequencer.
package fp16_pkg;

  localparam int unsigned FP16_W = 16;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;

  // Nominal adder request-to-result latency in cycles.
  localparam int unsigned ADDER_LATENCY = 7;

  typedef enum logic [2:0] {
    StIdle,
    StLoadFirst,
    StWaitIn,
    StIssue,
    StWaitLow,
    StWaitHigh,
    StDone,
    StErr
  } accum_state_e;

endpackage

// File: rtl/fp16_accum_ctrl.sv
// Streams FP16 elements into an external adder one pair at a time and folds the
// results into a running sum; pulses sum_valid once with the final value.
module fp16_accum_ctrl
  import fp16_pkg::*;
#(
  parameter int unsigned COUNT_W = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic               in_valid,
  input  logic [FP16_W-1:0]  in_data,
  output logic               in_ready,
  output logic               add_req,
  output logic [FP16_W-1:0]  add_a,
  output logic [FP16_W-1:0]  add_b,
  input  logic [FP16_W-1:0]  add_result,
  input  logic               add_done,
  output logic [FP16_W-1:0]  sum,
  output logic               sum_valid,
  output logic               busy,
  output logic               error
);

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

  accum_state_e       state;
  logic [FP16_W-1:0]  acc;
  logic [COUNT_W-1:0] remaining;
  logic [COUNT_W-1:0] remaining_dec;
  logic [TimerW-1:0]  timer;
  logic               handshake;

  assign remaining_dec = remaining - COUNT_W'(1);
  assign handshake     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      acc       <= FP16_ZERO;
      remaining <= '0;
      timer     <= '0;
      in_ready  <= 1'b0;
      add_req   <= 1'b0;
      add_a     <= FP16_ZERO;
      add_b     <= FP16_ZERO;
      sum       <= FP16_ZERO;
      sum_valid <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            error <= 1'b0;
            if (len == '0) begin
              acc       <= FP16_ZERO;
              sum       <= FP16_ZERO;
              sum_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= StDone;
            end else begin
              busy      <= 1'b1;
              remaining <= len - COUNT_W'(1);
              in_ready  <= 1'b1;
              state     <= StLoadFirst;
            end
          end
        end

        StLoadFirst: begin
          if (handshake) begin
            acc <= in_data;
            if (remaining == '0) begin
              in_ready  <= 1'b0;
              sum       <= in_data;
              sum_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= StDone;
            end else begin
              state <= StWaitIn;
            end
          end
        end

        StWaitIn: begin
          // Operands are frozen here and held until the adder result returns.
          if (handshake) begin
            add_a    <= acc;
            add_b    <= in_data;
            in_ready <= 1'b0;
            add_req  <= 1'b1;
            state    <= StIssue;
          end
        end

        StIssue: begin
          add_req <= 1'b0;
          timer   <= '0;
          state   <= StWaitLow;
        end

        StWaitLow: begin
          if (!add_done) begin
            timer <= '0;
            state <= StWaitHigh;
          end else if (timer == TimerLast) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= StErr;
          end else begin
            timer <= timer + TimerW'(1);
          end
        end

        StWaitHigh: begin
          if (add_done) begin
            acc       <= add_result;
            remaining <= remaining_dec;
            if (remaining_dec == '0) begin
              sum       <= add_result;
              sum_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= StDone;
            end else begin
              in_ready <= 1'b1;
              state    <= StWaitIn;
            end
          end else if (timer == TimerLast) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= StErr;
          end else begin
            timer <= timer + TimerW'(1);
          end
        end

        StDone:  state <= StIdle;
        StErr:   state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_accum_ctrl.sv
// Randomized bench for fp16_accum_ctrl with a behavioural FP16 adder stub and a
// fold-based sum model; per-cycle protocol checks plus per-transaction checks.
module tb_fp16_accum_ctrl;
  import fp16_pkg::*;

  localparam int unsigned COUNT_W = 8;
  localparam int unsigned TIMEOUT = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [COUNT_W-1:0] len = '0;
  logic               in_valid = 1'b0;
  logic [15:0]        in_data = '0;
  logic               in_ready;
  logic               add_req;
  logic [15:0]        add_a, add_b;
  logic [15:0]        add_result = '0;
  logic               add_done = 1'b1;
  logic [15:0]        sum;
  logic               sum_valid;
  logic               busy;
  logic               error;

  fp16_accum_ctrl #(.COUNT_W(COUNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .add_req(add_req), .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .add_done(add_done), .sum(sum), .sum_valid(sum_valid),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---- FP16 value conversion (normal numbers only) ----
  function automatic real f2r(input logic [15:0] h);
    real v;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) begin
      v = real'(h[9:0]) / 1024.0;
      e = -14;
    end else begin
      v = 1.0 + real'(h[9:0]) / 1024.0;
      e = e - 15;
    end
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2f(input real r);
    logic s;
    real  a;
    int   e;
    int   m;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = int'((a - 1.0) * 1024.0);
    return {s, 5'(e + 15), 10'(m)};
  endfunction

  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // ---- Adder stub: done falls the cycle after req, rises ADDER_LATENCY after req ----
  logic        stuck = 1'b0;
  logic [15:0] st_a = '0, st_b = '0;
  int          st_cnt = 0;
  logic        st_busy = 1'b0;

  always @(posedge clk) begin
    if (stuck) begin
      add_done <= 1'b1;
      st_cnt   <= 0;
      st_busy  <= 1'b0;
    end else if (add_req) begin
      add_done <= 1'b0;
      st_cnt   <= int'(ADDER_LATENCY) - 1;
      st_a     <= add_a;
      st_b     <= add_b;
      st_busy  <= 1'b1;
    end else if (st_cnt > 0) begin
      st_cnt <= st_cnt - 1;
      if (st_cnt == 1) begin
        add_done   <= 1'b1;
        add_result <= fadd(st_a, st_b);
        st_busy    <= 1'b0;
      end
    end
  end

  // ---- Model state and per-cycle compare ----
  logic [15:0] exp_q[$];
  logic [15:0] last_sum = 16'h0000;
  logic        exp_err = 1'b0;
  bit          err_dc = 1'b0;
  bit          sv_seen = 1'b0;
  int          sv_cyc = 0, sv_count = 0, req_count = 0, ir_cycles = 0, hs_count = 0;
  logic        prev_req = 1'b0, prev_done = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      if (sum_valid) begin
        sv_seen = 1'b1;
        sv_cyc  = cyc;
        sv_count++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "sum_valid_unexpected", 32'(sum), 32'(last_sum));
        end else begin
          last_sum = exp_q.pop_front();
          chk(sum == last_sum, "sum", 32'(sum), 32'(last_sum));
        end
      end else begin
        chk(sum == last_sum, "sum_hold", 32'(sum), 32'(last_sum));
      end
      if (!err_dc) chk(error == exp_err, "error", 32'(error), 32'(exp_err));
      if (in_ready) begin
        ir_cycles++;
        chk(busy, "in_ready_while_not_busy", 32'(busy), 32'd1);
      end
      if (in_ready && in_valid) hs_count++;
      if (add_req) begin
        req_count++;
        chk(!prev_req, "add_req_single_cycle", 32'(prev_req), 32'd0);
      end
      if (add_done && !prev_done)
        chk(!add_req, "add_req_at_done_rise", 32'(add_req), 32'd0);
      if (st_busy && busy) begin
        chk(add_a == st_a, "add_a_stable", 32'(add_a), 32'(st_a));
        chk(add_b == st_b, "add_b_stable", 32'(add_b), 32'(st_b));
      end
      prev_req  = add_req;
      prev_done = add_done;
    end
  end

  // ---- Driver ----
  logic [15:0] elems[$];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_txn(input int n, input int gap, input bit dbl, input bit chk_lat,
                         input bit tmo);
    logic [15:0] e;
    int start_cyc;
    int w;
    bit stalled;
    e = FP16_ZERO;
    if (n > 0) e = elems[0];
    for (int i = 1; i < n; i++) e = fadd(e, elems[i]);
    if (!tmo) exp_q.push_back(e);
    sv_seen = 0; sv_count = 0; req_count = 0; ir_cycles = 0; hs_count = 0;
    stalled = 0;
    len = COUNT_W'(n);
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    exp_err = 1'b0;
    if (tmo) err_dc = 1'b1;
    for (int i = 0; i < n && !stalled; i++) begin
      for (int g = 0; g < gap; g++) begin
        if (dbl && i == 1 && g == 0) start = 1'b1;
        tick();
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = elems[i];
      w = 0;
      while (!in_ready && w < 200) begin tick(); w++; end
      if (w >= 200) begin
        chk(1'b0, "in_ready_wait_expired", 32'(w), 32'd0);
        stalled = 1;
      end else begin
        tick();
      end
      in_valid = 1'b0;
    end
    w = 0;
    while (!sv_seen && !(tmo && error) && w < 500) begin tick(); w++; end
    chk(w < 500, "completion_wait_expired", 32'(w), 32'd0);
    if (tmo) begin
      chk(cyc == start_cyc + 4 + int'(TIMEOUT), "timeout_cycle", 32'(cyc),
          32'(start_cyc + 4 + int'(TIMEOUT)));
      chk(!busy, "busy_after_err", 32'(busy), 32'd0);
      chk(error, "error_set", 32'(error), 32'd1);
      err_dc  = 1'b0;
      exp_err = 1'b1;
    end
    repeat (3) tick();
    chk(sv_count == (tmo ? 0 : 1), "sum_valid_pulses", 32'(sv_count), 32'(tmo ? 0 : 1));
    chk(req_count == (tmo ? 1 : (n > 0 ? n - 1 : 0)), "add_req_count", 32'(req_count),
        32'(tmo ? 1 : (n > 0 ? n - 1 : 0)));
    chk(hs_count == n, "handshakes", 32'(hs_count), 32'(n));
    if (n == 0) chk(ir_cycles == 0, "in_ready_len0", 32'(ir_cycles), 32'd0);
    if (chk_lat && !tmo) begin
      w = (n == 0) ? 1 : 2 + 9 * (n - 1);
      chk(sv_cyc == start_cyc + w, "latency", 32'(sv_cyc - start_cyc), 32'(w));
    end
    chk(!busy, "busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #1;
    chk(in_ready == 0 && add_req == 0 && busy == 0 && error == 0 && sum_valid == 0,
        "reset_ctrl", {in_ready, add_req, busy, error, sum_valid}, 32'd0);
    chk(sum == 0 && add_a == 0 && add_b == 0, "reset_data", 32'(sum), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    // 1.0 + 2.0 + 0.5 = 3.5
    elems = '{16'h3C00, 16'h4000, 16'h3800};
    run_txn(3, 0, 0, 1, 0);
    chk(sum == 16'h4300, "len3_literal", 32'(sum), 32'h4300);

    elems = '{16'h4200};
    run_txn(1, 0, 0, 1, 0);
    chk(sum == 16'h4200, "len1_literal", 32'(sum), 32'h4200);

    run_txn(0, 0, 0, 1, 0);
    chk(sum == 16'h0000, "len0_literal", 32'(sum), 32'h0000);

    // Adder never acknowledges.
    stuck = 1'b1;
    elems = '{16'h3C00, 16'h4000};
    run_txn(2, 0, 0, 0, 1);
    chk(sum == 16'h0000, "sum_kept_after_err", 32'(sum), 32'h0000);
    stuck = 1'b0;
    repeat (2) tick();

    // Gapped input with a second start while busy; error clears on this start.
    elems = '{16'h3C00, 16'hBC00};
    run_txn(2, 5, 1, 0, 0);
    chk(sum == 16'h0000, "one_minus_one", 32'(sum), 32'h0000);

    elems = '{16'h4400, 16'h3C00};
    run_txn(2, 0, 0, 1, 0);
    chk(sum == 16'h4500, "four_plus_one", 32'(sum), 32'h4500);

    // Reset while waiting for the adder result.
    elems = '{16'h3C00, 16'h4000};
    len = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h3C00;
    tick();
    in_data = 16'h4000;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk(add_req == 0 && busy == 0 && in_ready == 0 && error == 0, "reset_mid_ctrl",
        {add_req, busy, in_ready, error}, 32'd0);
    chk(sum == 16'h0000, "reset_mid_sum", 32'(sum), 32'h0000);
    exp_q.delete();
    last_sum = 16'h0000;
    exp_err = 1'b0;
    tick();
    rst = 1'b0;
    prev_req = 1'b0;
    repeat (10) tick();
    elems = '{16'h3C00};
    run_txn(1, 0, 0, 1, 0);
    chk(sum == 16'h3C00, "after_reset_len1", 32'(sum), 32'h3C00);

    // Randomized: quarter-step values in [-8, 8], short vectors so sums stay exact.
    for (int t = 0; t < 40; t++) begin
      int n, gap, k;
      n = int'($urandom_range(0, 8));
      gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
      elems.delete();
      for (int i = 0; i < n; i++) begin
        k = int'($urandom_range(0, 64)) - 32;
        elems.push_back(r2f(real'(k) / 4.0));
      end
      run_txn(n, gap, 0, gap == 0, 0);
      repeat (int'($urandom_range(0, 3))) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, failed);
    $fatal(1);
  end

endmodule

// File: doc/fp16_accum_ctrl.md
Name: fp16_accum_ctrl

Overview:
Sequencer that sits directly upstream of the FP16 adder and also consumes its results. It takes a vector of half-precision values over a valid/ready stream and drives the adder's add/number1/number2 request interface one pair at a time. It folds the adder's result back in as a running sum and emits the final sum with a one-cycle valid pulse. The adder sits outside this block, so a bench can replace it with a stub.

Parameters:
COUNT_W, 8, width of the vector-length field (max 255 elements)
TIMEOUT, 16, max cycles to wait for any add_done transition before flagging an error

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  begin accumulation; sampled only in IDLE
len  in  COUNT_W  element count, captured with start
in_valid  in  1  input element valid
in_data  in  16  FP16 input element
in_ready  out  1  element accepted when in_valid && in_ready
add_req  out  1  to adder add; one-cycle pulse
add_a  out  16  to adder number1 (running sum)
add_b  out  16  to adder number2 (new element)
add_result  in  16  from adder result
add_done  in  1  from adder ready
sum  out  16  final sum; held until next start
sum_valid  out  1  one-cycle pulse when sum updates
busy  out  1  high from accepted start until DONE/ERR exit
error  out  1  sticky timeout flag; cleared by next accepted start

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; acc=0; remaining=0; timer=0.
- States: IDLE, LOAD_FIRST, WAIT_IN, ISSUE, WAIT_LOW, WAIT_HIGH, DONE, ERR.
- IDLE:
  - start=1 clears error and sets busy.
  - len==0: go DONE with acc=0x0000.
  - Otherwise: remaining=len-1, go LOAD_FIRST.
  - start while busy is ignored.
- LOAD_FIRST: in_ready=1. On handshake, acc=in_data. Go DONE if remaining==0, else WAIT_IN.
- WAIT_IN: in_ready=1. On handshake, add_b=in_data and add_a=acc, go ISSUE. in_ready is 0 in every other state.
- ISSUE: add_req=1 for exactly this cycle; go WAIT_LOW. add_a/add_b stay stable from ISSUE until WAIT_HIGH exits, because the adder samples its operands across several cycles.
- WAIT_LOW: wait for add_done==0 (adder acknowledgment), then go WAIT_HIGH.
- WAIT_HIGH: on add_done==1, acc=add_result and remaining-=1. Go DONE if remaining==0, else WAIT_IN.
- Timer:
  - Reset on entry to WAIT_LOW and WAIT_HIGH; increments each cycle in those states.
  - Reaching TIMEOUT goes to ERR.
- DONE: sum=acc, sum_valid=1 for one cycle, busy=0, go IDLE.
- ERR: error=1, busy=0, sum unchanged, no sum_valid, go IDLE.
- Nominal adder timing:
  - add_done low in cycle c+1 after the add_req cycle c; high again at c+7.
  - Per-element cost: 1 (WAIT_IN handshake) + 1 (ISSUE) + ~7 = ~9 cycles when input is always valid.
  - len=1 finishes 2 cycles after the start cycle, with no adder use.
- add_req must never stay high when add_done rises; otherwise the adder restarts.
- Arithmetic: none in this block. acc is a 16-bit register; rounding/overflow come from the adder.
- Reset mid-operation: add_req drops immediately. The adder may finish a stale operation; its result is ignored because state=IDLE.

Decomposition:
- Package fp16_pkg:
  - FP16_W=16; FP16_ZERO=16'h0000; FP16_ONE=16'h3C00.
  - accum state enum.
  - ADDER_LATENCY=7 constant for benches.
- No sub-module: single FSM plus counters. The top level instantiates fp16_accum_ctrl next to the adder.

Test Plan:
- len=3, inputs 0x3C00, 0x4000, 0x3800 with real adder -> one sum_valid pulse, sum=0x4300 (3.5), add_req pulsed exactly twice.
- len=1, input 0x4200 -> sum=0x4200 two cycles after start, add_req never asserted.
- len=0 -> sum=0x0000 with sum_valid the cycle after start; in_ready never high.
- Adder stub holds add_done=1 forever, len=2 -> error=1 after TIMEOUT cycles in WAIT_LOW, busy=0, no sum_valid; next start clears error.
- in_valid gaps of 5 cycles, plus start pulsed again while busy, len=2, inputs 0x3C00, 0xBC00 -> second start ignored, sum equals adder output for 1.0+(-1.0).
- rst asserted during WAIT_HIGH -> same-cycle add_req=0, busy=0, sum=0. New start with len=1, input 0x3C00 -> sum=0x3C00.
